intirvx_register_manager: RTL and testbench

- Consumer end of the write-back bus. Holds the architectural integer register file (x0..x31) and commits every wb_bus write.
- Serves decode: two combinational read ports with same-cycle write-back bypass.
- Runs a per-register pending-write scoreboard. Decode issue is stalled on RAW hazards and on scoreboard saturation.
- The scoreboard is cleared on pipeline flush.

---
 rtl/intirvx_register_manager_if.sv | 35 +++
 rtl/intirvx_register_manager.sv | 92 +++++++++
 tb/tb_intirvx_register_manager.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/intirvx_register_manager_if.sv
// Decode/write-back side bundle for the integer register manager.
// The slave modport is the manager; the master modport is decode plus the write-back source.
interface intirvx_register_manager_if #(
    parameter int XLEN = 32
);
    struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      adr;
    } wb;
    logic            wb_valid;
    logic            flush;
    logic            iss_valid;
    logic            iss_ready;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic            iss_rs1_v;
    logic            iss_rs2_v;
    logic [4:0]      iss_rd;
    logic            iss_rd_v;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            sb_err;

    modport slave (
        input  wb, wb_valid, flush,
        input  iss_valid, iss_rs1, iss_rs2, iss_rs1_v, iss_rs2_v, iss_rd, iss_rd_v,
        output iss_ready, rs1_data, rs2_data, sb_err
    );

    modport master (
        output wb, wb_valid, flush,
        output iss_valid, iss_rs1, iss_rs2, iss_rs1_v, iss_rs2_v, iss_rd, iss_rd_v,
        input  iss_ready, rs1_data, rs2_data, sb_err
    );
endinterface

// File: rtl/intirvx_register_manager.sv
// Architectural integer register file with write-back bypass and a per-register
// pending-write scoreboard that stalls decode on RAW hazards and counter saturation.
module intirvx_register_manager #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    intirvx_register_manager_if.slave     bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  regs [1:31];
    logic [CNT_W-1:0] cnt  [1:31];
    logic             sb_err_q;

    logic             wb_hit;
    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic [XLEN-1:0]  reg_rs1, reg_rs2;
    logic             hazard_rs1, hazard_rs2, rd_full;
    logic             iss_ready_c, iss_fire;

    // A source stalls while writes are outstanding, unless the last one lands this cycle.
    function automatic logic src_hazard(input logic used, input logic [4:0] rs,
                                        input logic [CNT_W-1:0] c, input logic landing);
        return used && (rs != 5'd0) && (c != '0) && !((c == CNT_ONE) && landing);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        if (inc && !dec) return c + CNT_ONE;
        if (dec && !inc) return c - CNT_ONE;
        return c;
    endfunction

    always_comb begin
        wb_hit  = bus.wb_valid && (bus.wb.adr != 5'd0);
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        cnt_wb  = '0;
        reg_rs1 = '0;
        reg_rs2 = '0;
        if (bus.iss_rs1 != 5'd0) begin
            cnt_rs1 = cnt[bus.iss_rs1];
            reg_rs1 = regs[bus.iss_rs1];
        end
        if (bus.iss_rs2 != 5'd0) begin
            cnt_rs2 = cnt[bus.iss_rs2];
            reg_rs2 = regs[bus.iss_rs2];
        end
        if (bus.iss_rd != 5'd0) cnt_rd = cnt[bus.iss_rd];
        if (wb_hit) cnt_wb = cnt[bus.wb.adr];

        bus.rs1_data = (wb_hit && bus.wb.adr == bus.iss_rs1) ? bus.wb.data : reg_rs1;
        bus.rs2_data = (wb_hit && bus.wb.adr == bus.iss_rs2) ? bus.wb.data : reg_rs2;

        hazard_rs1  = src_hazard(bus.iss_rs1_v, bus.iss_rs1, cnt_rs1,
                                 wb_hit && bus.wb.adr == bus.iss_rs1);
        hazard_rs2  = src_hazard(bus.iss_rs2_v, bus.iss_rs2, cnt_rs2,
                                 wb_hit && bus.wb.adr == bus.iss_rs2);
        rd_full     = bus.iss_rd_v && (bus.iss_rd != 5'd0) && (cnt_rd == '1);
        iss_ready_c = rst_n && !bus.flush && !hazard_rs1 && !hazard_rs2 && !rd_full;
        iss_fire    = bus.iss_valid && iss_ready_c && bus.iss_rd_v && (bus.iss_rd != 5'd0);

        bus.iss_ready = iss_ready_c;
        bus.sb_err    = sb_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (wb_hit) regs[bus.wb.adr] <= bus.wb.data;
            if (wb_hit && cnt_wb == '0) sb_err_q <= 1'b1;
            // Flush discards every pending count, including this cycle's decrement.
            for (int i = 1; i < 32; i++) begin
                if (bus.flush) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt_next(cnt[i],
                                       iss_fire && bus.iss_rd == 5'(i),
                                       wb_hit && bus.wb.adr == 5'(i) && cnt[i] != '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_intirvx_register_manager.sv
// Directed bench for intirvx_register_manager: a count-based scoreboard model is
// checked every cycle, alongside hand-computed literal expectations.
module tb_intirvx_register_manager;
    localparam int XLEN    = 32;
    localparam int CNT_MAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intirvx_register_manager_if #(.XLEN(XLEN)) bus ();

    intirvx_register_manager #(.XLEN(XLEN), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_err;
    logic        exp_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (bus.wb_valid && bus.wb.adr == rs) return bus.wb.data;
        return m_reg[rs];
    endfunction

    function automatic logic m_blocked(input logic used, input logic [4:0] rs);
        if (!used || rs == 5'd0) return 1'b0;
        if (m_cnt[rs] == 0) return 1'b0;
        if (m_cnt[rs] == 1 && bus.wb_valid && bus.wb.adr == rs) return 1'b0;
        return 1'b1;
    endfunction

    // Model: compare outputs mid-cycle, then apply this cycle's effects to the model state.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 32'd0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end
        exp_rdy = rst_n && !bus.flush
                  && !m_blocked(bus.iss_rs1_v, bus.iss_rs1)
                  && !m_blocked(bus.iss_rs2_v, bus.iss_rs2)
                  && !(bus.iss_rd_v && bus.iss_rd != 5'd0 && m_cnt[bus.iss_rd] >= CNT_MAX);
        check("model_iss_ready", {31'd0, bus.iss_ready}, {31'd0, exp_rdy});
        check("model_rs1_data", bus.rs1_data, m_read(bus.iss_rs1));
        check("model_rs2_data", bus.rs2_data, m_read(bus.iss_rs2));
        check("model_sb_err", {31'd0, bus.sb_err}, {31'd0, m_err});
        if (rst_n) begin
            if (bus.wb_valid && bus.wb.adr != 5'd0) begin
                m_reg[bus.wb.adr] = bus.wb.data;
                if (m_cnt[bus.wb.adr] == 0) m_err = 1'b1;
                else if (!bus.flush) m_cnt[bus.wb.adr] = m_cnt[bus.wb.adr] - 1;
            end
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            end else if (bus.iss_valid && exp_rdy && bus.iss_rd_v && bus.iss_rd != 5'd0) begin
                m_cnt[bus.iss_rd] = m_cnt[bus.iss_rd] + 1;
            end
        end
    end

    task automatic idle();
        bus.wb.data   = '0;
        bus.wb.adr    = '0;
        bus.wb_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.iss_valid = 1'b0;
        bus.iss_rs1   = '0;
        bus.iss_rs2   = '0;
        bus.iss_rs1_v = 1'b0;
        bus.iss_rs2_v = 1'b0;
        bus.iss_rd    = '0;
        bus.iss_rd_v  = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic rd_v,
                         input logic [4:0] rs1, input logic rs1_v,
                         input logic [4:0] rs2, input logic rs2_v);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = rd;
        bus.iss_rd_v  = rd_v;
        bus.iss_rs1   = rs1;
        bus.iss_rs1_v = rs1_v;
        bus.iss_rs2   = rs2;
        bus.iss_rs2_v = rs2_v;
    endtask

    task automatic wb(input logic [4:0] adr, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb.adr   = adr;
        bus.wb.data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (2) @(negedge clk);
        check("reset_iss_ready", {31'd0, bus.iss_ready}, 32'd0);
        check("reset_sb_err", {31'd0, bus.sb_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            cyc();
            bus.iss_rs1 = 5'(i);
            bus.iss_rs2 = 5'(31 - i);
            @(negedge clk);
            check("reset_read_rs1", bus.rs1_data, 32'd0);
            if (i == 0) begin
                check("idle_iss_ready", {31'd0, bus.iss_ready}, 32'd1);
                check("idle_sb_err", {31'd0, bus.sb_err}, 32'd0);
            end
        end

        // RAW hazard on x5 released by a same-cycle write-back.
        cyc(); issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk); check("issue_rd5_ready", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk); check("raw_x5_stall", {31'd0, bus.iss_ready}, 32'd0);
        cyc(); issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0); wb(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        check("raw_x5_bypass_ready", {31'd0, bus.iss_ready}, 32'd1);
        check("raw_x5_bypass_data", bus.rs1_data, 32'hDEAD_BEEF);
        cyc(); issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check("x5_array_data", bus.rs1_data, 32'hDEAD_BEEF);
        check("x5_array_ready", {31'd0, bus.iss_ready}, 32'd1);

        // Saturation of x7 at three in-flight writes.
        for (int k = 0; k < 3; k++) begin
            cyc(); issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            @(negedge clk); check("x7_fill_ready", {31'd0, bus.iss_ready}, 32'd1);
        end
        cyc(); issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); wb(5'd7, 32'h0000_0077);
        @(negedge clk); check("x7_full_with_wb", {31'd0, bus.iss_ready}, 32'd0);
        cyc(); issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk); check("x7_release", {31'd0, bus.iss_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(); wb(5'd7, 32'h0000_0100 + 32'(k));
            @(negedge clk);
        end
        cyc(); bus.iss_rs2 = 5'd7;
        @(negedge clk);
        check("x7_drained_data", bus.rs2_data, 32'h0000_0102);
        check("x7_drained_sb_err", {31'd0, bus.sb_err}, 32'd0);

        // Flush clears x3's pending write; its late write-back then flags sb_err.
        cyc(); issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        cyc(); issue(5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0); bus.flush = 1'b1;
        @(negedge clk); check("flush_blocks_issue", {31'd0, bus.iss_ready}, 32'd0);
        cyc(); issue(5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        @(negedge clk); check("post_flush_x3_ready", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); wb(5'd3, 32'h0000_0001); bus.iss_rs1 = 5'd3;
        @(negedge clk);
        check("late_wb_bypass", bus.rs1_data, 32'h0000_0001);
        check("late_wb_err_not_yet", {31'd0, bus.sb_err}, 32'd0);
        cyc(); bus.iss_rs1 = 5'd3;
        @(negedge clk);
        check("late_wb_data", bus.rs1_data, 32'h0000_0001);
        check("late_wb_sb_err", {31'd0, bus.sb_err}, 32'd1);

        // x0 writes dropped, x0 never scoreboarded.
        cyc(); wb(5'd0, 32'hFFFF_FFFF); bus.iss_rs1 = 5'd0;
        @(negedge clk); check("x0_bypass_blocked", bus.rs1_data, 32'd0);
        cyc(); bus.iss_rs1 = 5'd0;
        @(negedge clk);
        check("x0_reads_zero", bus.rs1_data, 32'd0);
        check("x0_sb_err_kept", {31'd0, bus.sb_err}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            cyc(); issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
            @(negedge clk); check("x0_rd_never_stalls", {31'd0, bus.iss_ready}, 32'd1);
        end

        // Simultaneous increment and decrement on x9 leaves one write pending.
        cyc(); issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        cyc(); issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); wb(5'd9, 32'h0000_0099);
        @(negedge clk); check("x9_inc_dec_ready", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        @(negedge clk);
        check("x9_still_pending", {31'd0, bus.iss_ready}, 32'd0);
        check("x9_updated", bus.rs2_data, 32'h0000_0099);
        cyc(); issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); wb(5'd9, 32'h0000_00AA);
        @(negedge clk);
        check("x9_last_landing", {31'd0, bus.iss_ready}, 32'd1);
        check("x9_last_data", bus.rs2_data, 32'h0000_00AA);

        // Asynchronous reset between edges.
        cyc(); bus.iss_rs1 = 5'd9;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, bus.iss_ready}, 32'd0);
        check("async_rst_sb_err", {31'd0, bus.sb_err}, 32'd0);
        check("async_rst_x9", bus.rs1_data, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(); bus.iss_rs1 = 5'd5;
        @(negedge clk);
        check("after_rst_x5", bus.rs1_data, 32'd0);
        check("after_rst_ready", {31'd0, bus.iss_ready}, 32'd1);

        cyc();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
